// File: rtl/vid_line_doubler.sv
// -----------------------------------------------------------------------------
// vid_line_doubler
//
// Scanline doubler for the video output path. Each active input line is
// captured into one bank of a ping-pong line buffer. Every captured line is
// then replayed twice at the output pixel rate. Each replay has its own
// horizontal front porch, sync pulse and back porch, so the output line rate
// is twice the input line rate.
//
// Ports
//   I_clock      system clock (single clock domain)
//   I_reset      synchronous, active-low reset
//   I_in_tick    input pixel strobe (one-cycle pulse)
//   I_in_blank   input blank, high outside active video
//   I_in_hsync   input hsync (carried for completeness, not used)
//   I_in_vsync   input vsync, re-sampled on every output tick
//   I_in_rgb     input pixel
//   I_out_tick   output pixel strobe (one-cycle pulse, ~2x input rate)
//   O_vid_blank  output blank
//   O_vid_hsync  output hsync, active high
//   O_vid_vsync  output vsync, active high
//   O_vid_rgb    output pixel, zero while blanked
//   O_overrun    sticky flag: a captured line was dropped before replay
// -----------------------------------------------------------------------------
module vid_line_doubler #(
  parameter int P_max_pixels = 512,
  parameter int P_color_bits = 24,
  parameter int P_hfront     = 16,
  parameter int P_hsync      = 32,
  parameter int P_hback      = 16
) (
  input  logic                    I_clock,
  input  logic                    I_reset,
  input  logic                    I_in_tick,
  input  logic                    I_in_blank,
  input  logic                    I_in_hsync,
  input  logic                    I_in_vsync,
  input  logic [P_color_bits-1:0] I_in_rgb,
  input  logic                    I_out_tick,
  output logic                    O_vid_blank,
  output logic                    O_vid_hsync,
  output logic                    O_vid_vsync,
  output logic [P_color_bits-1:0] O_vid_rgb,
  output logic                    O_overrun
);

  // AW addresses one bank; PW also holds the count P_max_pixels itself.
  localparam int AW   = $clog2(P_max_pixels);
  localparam int PW   = $clog2(P_max_pixels + 1);
  localparam int HMAX = (P_hfront > P_hsync) ?
                        ((P_hfront > P_hback) ? P_hfront : P_hback) :
                        ((P_hsync  > P_hback) ? P_hsync  : P_hback);
  localparam int CW   = $clog2(HMAX + 1);

  localparam logic [PW-1:0] MAX_PTR = PW'(P_max_pixels);
  localparam logic [CW-1:0] HF_LAST = CW'(P_hfront - 1);
  localparam logic [CW-1:0] HS_LAST = CW'(P_hsync - 1);
  localparam logic [CW-1:0] HB_LAST = CW'(P_hback - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACTIVE,
    S_FRONT,
    S_SYNC,
    S_BACK
  } state_t;

  // Input hsync is part of the stream bundle but carries no information here.
  logic unused_in_hsync;
  assign unused_in_hsync = I_in_hsync;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  // Write side
  logic [PW-1:0] wptr_q, wptr_d;
  logic          wbank_q, wbank_d;
  logic [PW-1:0] len_q, len_d;
  logic          pending_q, pending_d;
  logic          overrun_q, overrun_d;
  // Read side
  state_t        state_q, state_d;
  logic          rbank_q, rbank_d;
  logic [PW-1:0] rlen_q, rlen_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic          rep_q, rep_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // Registered outputs
  logic          blank_q, blank_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic [P_color_bits-1:0] rgb_q;

  // Combinational helpers
  logic          wr_en;
  logic          line_end;
  logic          take;
  logic          emit_px;
  logic          px_bank;
  logic [PW-1:0] px_ptr;
  logic [PW-1:0] px_len;

  logic [AW:0]   wr_addr;
  logic [AW:0]   rd_addr;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned below gets a default first, so no path can
    // leave one unassigned and infer a latch.
    wptr_d    = wptr_q;
    wbank_d   = wbank_q;
    len_d     = len_q;
    pending_d = pending_q;
    overrun_d = overrun_q;
    state_d   = state_q;
    rbank_d   = rbank_q;
    rlen_d    = rlen_q;
    rptr_d    = rptr_q;
    rep_d     = rep_q;
    cnt_d     = cnt_q;
    blank_d   = blank_q;
    hsync_d   = hsync_q;
    vsync_d   = vsync_q;
    take      = 1'b0;
    emit_px   = 1'b0;
    px_bank   = rbank_q;
    px_ptr    = rptr_q;
    px_len    = rlen_q;

    wr_en    = I_in_tick && !I_in_blank && (wptr_q < MAX_PTR);
    line_end = I_in_tick &&  I_in_blank && (wptr_q != '0);

    // Read side: everything advances only on an output tick.
    if (I_out_tick) begin
      vsync_d = I_in_vsync;
      blank_d = 1'b1;
      hsync_d = 1'b0;

      unique case (state_q)
        S_IDLE: begin
          // Taking a line from IDLE emits its first pixel on this same tick,
          // which gives one tick of capture-to-output latency.
          if (pending_q) begin
            take    = 1'b1;
            emit_px = 1'b1;
            px_bank = ~wbank_q;
            px_ptr  = '0;
            px_len  = len_q;
            rbank_d = ~wbank_q;
            rlen_d  = len_q;
            rep_d   = 1'b0;
          end
        end

        S_ACTIVE: emit_px = 1'b1;

        S_FRONT: begin
          if (cnt_q == HF_LAST) begin
            state_d = S_SYNC;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        S_SYNC: begin
          hsync_d = 1'b1;
          if (cnt_q == HS_LAST) begin
            state_d = S_BACK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        S_BACK: begin
          if (cnt_q == HB_LAST) begin
            cnt_d  = '0;
            rptr_d = '0;
            if (!rep_q) begin
              rep_d   = 1'b1;
              state_d = S_ACTIVE;
            end else if (pending_q) begin
              // Back-to-back reload: the next line starts on the following
              // tick, keeping the output line period exact.
              take    = 1'b1;
              rbank_d = ~wbank_q;
              rlen_d  = len_q;
              rep_d   = 1'b0;
              state_d = S_ACTIVE;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        default: state_d = S_IDLE;
      endcase

      if (emit_px) begin
        blank_d = 1'b0;
        if (px_ptr == px_len - 1'b1) begin
          state_d = S_FRONT;
          cnt_d   = '0;
        end else begin
          state_d = S_ACTIVE;
          rptr_d  = px_ptr + 1'b1;
        end
      end
    end

    // Write side. wptr saturates at P_max_pixels; extra pixels are dropped.
    if (wr_en) begin
      wptr_d = wptr_q + 1'b1;
    end
    if (line_end) begin
      wptr_d    = '0;
      len_d     = wptr_q;
      wbank_d   = ~wbank_q;
      pending_d = 1'b1;
      // A take in this same cycle consumes the older line, so nothing is lost.
      if (pending_q && !take) begin
        overrun_d = 1'b1;
      end
    end else if (take) begin
      pending_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge I_clock) begin
    if (!I_reset) begin
      wptr_q    <= '0;
      wbank_q   <= 1'b0;
      len_q     <= '0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
      state_q   <= S_IDLE;
      rbank_q   <= 1'b0;
      rlen_q    <= '0;
      rptr_q    <= '0;
      rep_q     <= 1'b0;
      cnt_q     <= '0;
      blank_q   <= 1'b1;
      hsync_q   <= 1'b0;
      vsync_q   <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      wbank_q   <= wbank_d;
      len_q     <= len_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      state_q   <= state_d;
      rbank_q   <= rbank_d;
      rlen_q    <= rlen_d;
      rptr_q    <= rptr_d;
      rep_q     <= rep_d;
      cnt_q     <= cnt_d;
      blank_q   <= blank_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Line buffer: two banks, bank select is the address MSB.
  // ---------------------------------------------------------------------------
  logic [P_color_bits-1:0] line_mem [2**(AW+1)];

  assign wr_addr = {wbank_q, wptr_q[AW-1:0]};
  assign rd_addr = {px_bank, px_ptr[AW-1:0]};

  // NOTE: the array itself has no reset, so it maps onto block RAM; a line is
  // only ever read after all of its pixels have been written.
  always_ff @(posedge I_clock) begin
    if (wr_en) begin
      line_mem[wr_addr] <= I_in_rgb;
    end
  end

  // Read data register doubles as the output pixel register; it is cleared on
  // every blanked tick so the pixel output is zero outside active video.
  always_ff @(posedge I_clock) begin
    if (!I_reset) begin
      rgb_q <= '0;
    end else if (I_out_tick) begin
      rgb_q <= emit_px ? line_mem[rd_addr] : '0;
    end
  end

  assign O_vid_blank = blank_q;
  assign O_vid_hsync = hsync_q;
  assign O_vid_vsync = vsync_q;
  assign O_vid_rgb   = rgb_q;
  assign O_overrun   = overrun_q;

endmodule

// File: tb/tb_vid_line_doubler.sv
// -----------------------------------------------------------------------------
// tb_vid_line_doubler
//
// Directed bench for vid_line_doubler with porches 2/3/2. The output tick runs
// every second clock and input pixels arrive every fourth clock (or faster
// where a scenario needs it). Every output tick is recorded as
// {blank, hsync, rgb}. Recorded ticks are compared against sequences built
// from hand-derived line patterns: pixels, then 2 blank, 3 sync, and 2 blank
// ticks.
// -----------------------------------------------------------------------------
module tb_vid_line_doubler;

  localparam int CB = 24;
  localparam int HF = 2;
  localparam int HS = 3;
  localparam int HB = 2;

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b0;
  logic          in_tick  = 1'b0;
  logic          in_blank = 1'b1;
  logic          in_hsync = 1'b0;
  logic          in_vsync = 1'b0;
  logic [CB-1:0] in_rgb   = '0;
  logic          out_tick = 1'b0;
  logic          vid_blank;
  logic          vid_hsync;
  logic          vid_vsync;
  logic [CB-1:0] vid_rgb;
  logic          overrun;

  always #5 clk = ~clk;

  vid_line_doubler #(
    .P_max_pixels(512),
    .P_color_bits(CB),
    .P_hfront    (HF),
    .P_hsync     (HS),
    .P_hback     (HB)
  ) dut (
    .I_clock    (clk),
    .I_reset    (rst_n),
    .I_in_tick  (in_tick),
    .I_in_blank (in_blank),
    .I_in_hsync (in_hsync),
    .I_in_vsync (in_vsync),
    .I_in_rgb   (in_rgb),
    .I_out_tick (out_tick),
    .O_vid_blank(vid_blank),
    .O_vid_hsync(vid_hsync),
    .O_vid_vsync(vid_vsync),
    .O_vid_rgb  (vid_rgb),
    .O_overrun  (overrun)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  bit          out_en   = 1'b0;
  logic [63:0] obs[$];
  int          obs_cyc[$];
  logic [63:0] exp_q[$];

  function automatic logic [63:0] ent(input logic b, input logic h,
                                      input logic [CB-1:0] c);
    return {38'd0, b, h, c};
  endfunction

  localparam logic [63:0] IDLE_T = {38'd0, 1'b1, 1'b0, 24'd0};

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // One clock: drive inputs, step past the edge, record the output tick.
  task automatic cycle(input logic t, input logic b, input logic [CB-1:0] px);
    in_tick  = t;
    in_blank = b;
    in_rgb   = px;
    out_tick = out_en && (cyc % 2 == 0);
    @(posedge clk);
    #1;
    if (out_tick) begin
      obs.push_back(ent(vid_blank, vid_hsync, vid_rgb));
      obs_cyc.push_back(cyc);
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 1'b0, '0);
  endtask

  // Pixels base, base+1, ... with 'gap' idle clocks after each, then one
  // blank tick; e returns the cycle index of that blank tick.
  task automatic send_line(input int base, input int n, input int gap,
                           output int e);
    for (int i = 0; i < n; i++) begin
      cycle(1'b1, 1'b0, CB'(base + i));
      idle(gap);
    end
    e = cyc;
    cycle(1'b1, 1'b1, '0);
  endtask

  // Expected tick pattern of one replayed output line.
  task automatic push_line(input int base, input int len);
    for (int i = 0; i < len; i++) exp_q.push_back(ent(1'b0, 1'b0, CB'(base + i)));
    repeat (HF) exp_q.push_back(ent(1'b1, 1'b0, '0));
    repeat (HS) exp_q.push_back(ent(1'b1, 1'b1, '0));
    repeat (HB) exp_q.push_back(ent(1'b1, 1'b0, '0));
  endtask

  task automatic push_idle(input int n);
    repeat (n) exp_q.push_back(IDLE_T);
  endtask

  // Index of the first recorded tick after cycle e (the tick that takes a
  // line pending since e).
  function automatic int first_after(input int e);
    int n = 0;
    foreach (obs_cyc[i]) if (obs_cyc[i] <= e) n++;
    return n;
  endfunction

  task automatic check_seq(input int start, input string tag);
    if (start > 0) check({tag, "_pre"}, obs[start-1], IDLE_T);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (start + i < obs.size()) begin
        check($sformatf("%s[%0d]", tag, i), obs[start+i], exp_q[i]);
      end else begin
        n_checks++;
        $display("FAIL %s[%0d]: output tick missing, expected %h", tag, i, exp_q[i]);
      end
    end
  endtask

  task automatic check_all_idle(input string tag);
    foreach (obs[i]) check($sformatf("%s[%0d]", tag, i), obs[i], IDLE_T);
  endtask

  task automatic clear_rec();
    obs.delete();
    obs_cyc.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    clear_rec();
  endtask

  initial begin
    int e, e2, s;

    // Reset state
    out_en = 1'b1;
    rst_n  = 1'b0;
    idle(3);
    check("rst_out", ent(vid_blank, vid_hsync, vid_rgb), IDLE_T);
    check("rst_vsync", 64'(vid_vsync), 64'd0);
    check("rst_overrun", 64'(overrun), 64'd0);
    rst_n = 1'b1;
    clear_rec();

    // Vsync follows the input only on output ticks
    out_en   = 1'b0;
    in_vsync = 1'b1;
    idle(3);
    check("vsync_hold", 64'(vid_vsync), 64'd0);
    out_en = 1'b1;
    idle(2);
    check("vsync_set", 64'(vid_vsync), 64'd1);
    in_vsync = 1'b0;
    idle(2);
    check("vsync_clr", 64'(vid_vsync), 64'd0);
    clear_rec();

    // Single line of 4 pixels replayed twice
    send_line(32'h1, 4, 3, e);
    idle(60);
    push_line(32'h1, 4);
    push_line(32'h1, 4);
    push_idle(3);
    check_seq(first_after(e), "single");
    check("single_overrun", 64'(overrun), 64'd0);

    // Back-to-back A (4 px) and B (3 px): A,A,B,B with no idle tick between
    do_reset();
    send_line(32'hA0, 4, 3, e);
    send_line(32'hB0, 3, 3, e2);
    idle(80);
    push_line(32'hA0, 4);
    push_line(32'hA0, 4);
    push_line(32'hB0, 3);
    push_line(32'hB0, 3);
    push_idle(2);
    check_seq(first_after(e), "b2b");
    check("b2b_overrun", 64'(overrun), 64'd0);

    // Overrun: L2 and L3 both captured during L1's replay; L2 is dropped
    do_reset();
    send_line(32'h10, 4, 3, e);
    send_line(32'h20, 2, 0, e2);
    for (int k = 0; k < 100 && cyc < e + 34; k++) cycle(1'b0, 1'b0, '0);
    check("ovr_early", 64'(overrun), 64'd0);
    send_line(32'h30, 2, 0, e2);
    idle(80);
    push_line(32'h10, 4);
    push_line(32'h10, 4);
    push_line(32'h30, 2);
    push_line(32'h30, 2);
    push_idle(2);
    check_seq(first_after(e), "ovr");
    check("ovr_flag", 64'(overrun), 64'd1);
    idle(20);
    check("ovr_sticky", 64'(overrun), 64'd1);
    do_reset();
    check("ovr_rst", 64'(overrun), 64'd0);

    // Zero-length lines: blank ticks only, no output activity
    cycle(1'b1, 1'b1, '0);
    idle(3);
    cycle(1'b1, 1'b1, '0);
    idle(20);
    check_all_idle("zero");
    check("zero_overrun", 64'(overrun), 64'd0);
    clear_rec();
    send_line(32'h50, 3, 3, e);
    idle(60);
    push_line(32'h50, 3);
    push_line(32'h50, 3);
    push_idle(2);
    check_seq(first_after(e), "after_zero");

    // Clip: 520 input pixels, 512 replayed
    do_reset();
    send_line(32'h1000, 520, 3, e);
    idle(2200);
    push_line(32'h1000, 512);
    push_line(32'h1000, 512);
    push_idle(2);
    check_seq(first_after(e), "clip");

    // Reset during the second pixel of the first replay
    do_reset();
    in_vsync = 1'b1;
    send_line(32'h40, 4, 3, e);
    s = first_after(e);
    for (int k = 0; k < 40 && obs.size() < s + 2; k++) cycle(1'b0, 1'b0, '0);
    if (obs.size() < s + 2) begin
      n_checks++;
      $display("FAIL rst_mid_wait: replay not seen, got %0d ticks need %0d",
               obs.size(), s + 2);
    end else begin
      check("rst_mid_px", obs[s+1], ent(1'b0, 1'b0, 24'h41));
    end
    rst_n = 1'b0;
    cycle(1'b0, 1'b0, '0);
    check("rst_mid_out", ent(vid_blank, vid_hsync, vid_rgb), IDLE_T);
    check("rst_mid_vsync", 64'(vid_vsync), 64'd0);
    check("rst_mid_overrun", 64'(overrun), 64'd0);
    rst_n    = 1'b1;
    in_vsync = 1'b0;
    clear_rec();
    idle(60);
    check_all_idle("rst_idle");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
